div_sequencer: RTL and testbench

Multi-cycle sequencer for the integer divide unit in the execute stage. It accepts a DIV/DIVU issued in E, runs a radix-2 restoring division one quotient bit per cycle, and produces the HI (remainder) and LO (quotient) write data. It drives the `div_stallE` input of the hazard unit, which freezes F/D/E/M/W while a divide is in flight. It also honours an annul from exception/flush logic.

---
 rtl/div_sequencer_if.sv | 14 +
 rtl/div_sequencer.sv | 70 +++++++
 tb/tb_div_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: issue/result handshake between the execute stage and the divide sequencer.
interface div_sequencer_if #(parameter int WIDTH = 32);
    logic start_i;
    logic signed_i;
    logic annul_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic stall_o;
    logic valid_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    modport master (output start_i, signed_i, annul_i, a_i, b_i, input stall_o, valid_o, hi_o, lo_o);
    modport slave (input start_i, signed_i, annul_i, a_i, b_i, output stall_o, valid_o, hi_o, lo_o);
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring DIV/DIVU sequencer with hazard stall; DIV_ZERO_FAST_EN makes divide-by-zero finish in one cycle.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic clk,
    input logic resetn,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
    stateT state, nextState;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem, q, absA, absB, absBIn;
    logic [WIDTH:0] shifted, trial;
    logic signQ, signR, accept, lastStep, fastZero;
`ifdef DIV_ZERO_FAST_EN
    assign fastZero = bus.b_i == '0;
`else
    assign fastZero = 1'b0;
`endif
    always_comb begin
        absA = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
        absBIn = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
        accept = state == IDLE && bus.start_i && !bus.annul_i;
        lastStep = count == CNT_W'(WIDTH - 1);
        // Full rem is kept in the shift so large unsigned divisors cannot overflow the trial
        shifted = {rem, q[WIDTH-1]};
        trial = shifted - {1'b0, absB};
    end
    always_comb begin
        nextState = state;
        if (bus.annul_i)
            nextState = IDLE;
        else if (state == IDLE)
            nextState = bus.start_i ? (fastZero ? DONE : BUSY) : IDLE;
        else if (state == BUSY)
            nextState = lastStep ? DONE : BUSY;
        else
            nextState = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
            rem <= '0;
            q <= '0;
            absB <= '0;
            signQ <= 1'b0;
            signR <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                absB <= absBIn;
                signQ <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                signR <= bus.signed_i & bus.a_i[WIDTH-1];
                count <= '0;
                rem <= fastZero ? absA : '0;
                q <= fastZero ? '1 : absA;
            end else if (state == BUSY) begin
                rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                q <= {q[WIDTH-2:0], ~trial[WIDTH]};
                count <= count + 1'b1;
            end
        end
    end
    assign bus.stall_o = resetn && !bus.annul_i && ((state == IDLE && bus.start_i) || state == BUSY);
    assign bus.valid_o = resetn && !bus.annul_i && state == DONE;
    assign bus.lo_o = !resetn ? '0 : signQ ? -q : q;
    assign bus.hi_o = !resetn ? '0 : signR ? -rem : rem;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed divides with a scoreboard monitor checking results, latency and stall timing.
module tb_div_sequencer;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int due;
    } expT;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    logic clk = 1'b0;
    logic resetn;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    expT sb[$];
    div_sequencer_if #(.WIDTH(32)) bus();
    div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction
    initial forever begin
        expT e;
        @(negedge clk);
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("lo", bus.lo_o, e.lo);
                chk("hi", bus.hi_o, e.hi);
                chk("valid_cycle", cyc, e.due);
            end
        end
    end
    task automatic doDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expLo, input logic [31:0] expHi, input int lat,
                         input logic drop, input logic chkZero);
        int n;
        logic got;
        bus.signed_i = sgn;
        bus.a_i = a;
        bus.b_i = b;
        bus.start_i = 1'b1;
        sb.push_back('{expHi, expLo, cyc + lat});
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (i == 0 && chkZero) begin
                chk("post_reset_hi", bus.hi_o, 32'h0);
                chk("post_reset_lo", bus.lo_o, 32'h0);
            end
            if (bus.stall_o) n++;
            if (bus.valid_o) got = 1'b1;
        end
        chk("valid_seen", {31'b0, got}, 32'h1);
        chk("stall_cycles", n, lat);
        @(posedge clk);
        #1;
        if (drop) bus.start_i = 1'b0;
    endtask
    initial begin
        int c0;
        resetn = 1'b0;
        bus.start_i = 1'b1;
        bus.signed_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.a_i = 32'd100;
        bus.b_i = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'b0, bus.stall_o}, 32'h0);
        chk("reset_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("reset_hi", bus.hi_o, 32'h0);
        chk("reset_lo", bus.lo_o, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        doDiv(0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1, 1);
        doDiv(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1, 0);
        doDiv(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, 1, 0);
        doDiv(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1, 0);
        doDiv(1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE, 33, 1, 0);
        doDiv(0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 33, 1, 0);
        doDiv(0, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 33, 1, 0);
        doDiv(1, 32'h80000005, 32'h0, 32'd1, 32'h80000005, ZLAT, 1, 0);
        doDiv(0, 32'd5, 32'h0, 32'hFFFFFFFF, 32'd5, ZLAT, 1, 0);
        bus.signed_i = 1'b0;
        bus.a_i = 32'd20;
        bus.b_i = 32'd6;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_start_stall", {31'b0, bus.stall_o}, 32'h0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        doDiv(0, 32'd20, 32'd6, 32'd3, 32'd2, 33, 1, 0);
        bus.a_i = 32'd1000;
        bus.b_i = 32'd3;
        bus.start_i = 1'b1;
        c0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_stall", {31'b0, bus.stall_o}, 32'h0);
        chk("annul_valid", {31'b0, bus.valid_o}, 32'h0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        doDiv(0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1, 0);
        bus.a_i = 32'hFFFF;
        bus.b_i = 32'h10;
        bus.start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'b0, bus.stall_o}, 32'h0);
        chk("midrst_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("midrst_hi", bus.hi_o, 32'h0);
        chk("midrst_lo", bus.lo_o, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        doDiv(0, 32'hFFFF, 32'h10, 32'hFFF, 32'hF, 33, 1, 1);
        doDiv(0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0, 0);
        doDiv(0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 0, 0);
        doDiv(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1, 0);
        repeat (40) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
